// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - UART-style serial frame receiver with mid-bit sampling
//
// Receives start + DATA_BITS (LSB first) [+ even parity] + stop frames on rx.
// Optional feature macro: SERIAL_RX_PARITY_EN (adds PARITY state and parity_err).
//
// Ports:
//   clk        input   rising-edge clock
//   rst_n      input   asynchronous active-low reset
//   rx         input   asynchronous serial line, idle high
//   data_out   output  last correctly framed word (DATA_BITS wide)
//   valid      output  one-cycle pulse, data_out newly updated
//   frame_err  output  one-cycle pulse, stop bit sampled low
//   parity_err output  one-cycle pulse, parity mismatch (SERIAL_RX_PARITY_EN only)

module serial_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
`ifdef SERIAL_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [CW-1:0]         r_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
`ifdef SERIAL_RX_PARITY_EN
    logic                  r_par;
`endif

    logic w_rxs;
    logic w_mid;

    assign w_rxs = r_sync2;
    // After the half-bit start alignment, every full-bit count lands mid-bit.
    assign w_mid = (r_cnt == FULL_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_par      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_cnt <= '0;
                    if (!w_rxs) r_state <= S_START;
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt   <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        r_state <= w_rxs ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_mid) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                S_PARITY: begin
                    if (w_mid) begin
                        r_cnt   <= '0;
                        r_par   <= w_rxs;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_mid) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            // Returning to IDLE here lets a start edge half a
                            // bit later be caught for back-to-back frames.
                            r_state <= S_IDLE;
`ifdef SERIAL_RX_PARITY_EN
                            if (^{r_shift, r_par}) begin
                                parity_err <= 1'b1;
                            end else begin
                                data_out <= r_shift;
                                valid    <= 1'b1;
                            end
`else
                            data_out <= r_shift;
                            valid    <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    r_cnt <= '0;
                    if (w_rxs) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - randomized self-checking bench for serial_rx

module tb_serial_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic [DB-1:0] data_out;
    logic          valid;
    logic          frame_err;
`ifdef SERIAL_RX_PARITY_EN
    logic          parity_err;
`endif

    serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
`ifdef SERIAL_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: list of words expected on valid, plus error tallies.
    int exp_q[$];
    int got_q[$];
    int got_cyc[$];
    int exp_fe = 0;
    int got_fe = 0;
    int exp_pe = 0;
`ifdef SERIAL_RX_PARITY_EN
    int got_pe = 0;
`endif
    logic [DB-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_data", 32'(data_out), 0);
            check("rst_valid", 32'(valid), 0);
            check("rst_ferr", 32'(frame_err), 0);
            prev_data = '0;
        end else begin
            check("excl", 32'(valid & frame_err), 0);
            if (valid) begin
                got_q.push_back(int'(data_out));
                got_cyc.push_back(cyc);
                prev_data = data_out;
            end else begin
                check("hold", 32'(data_out), 32'(prev_data));
            end
            if (frame_err) got_fe++;
`ifdef SERIAL_RX_PARITY_EN
            check("excl_par", 32'(valid & parity_err), 0);
            if (parity_err) got_pe++;
`endif
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        send_bit(1'b1);
        for (int i = 1; i < n; i++) send_bit(1'b1);
    endtask

    // Sends one frame and records what a correct receiver must report.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par_flip);
        if (!stop)         exp_fe++;
        else if (par_flip) exp_pe++;
        else               exp_q.push_back(int'(d));
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop);
    endtask

    task automatic glitch(input int n);
        rx = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        idle_bits(1);
    endtask

    task automatic break_hold(input int n);
        rx = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        idle_bits(1);
    endtask

    int s;
    int n0;
    int lat;
    int gap;

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("rst_state_data", 32'(data_out), 0);
        rst_n = 1'b1;
        idle_bits(2);

        // 0xA5 with latency: 2 sync + 1 detect + half bit + 9 bits.
        s = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle_bits(2);
        check("a5_count", 32'(got_q.size()), 1);
        lat = (got_cyc.size() > 0) ? got_cyc[0] - s : -1;
        check("a5_latency", 32'(lat >= 154 && lat <= 155), 1);

        // Short low glitch rejected, then 0x3C.
        glitch(4);
        idle_bits(1);
        check("glitch_none", 32'(got_q.size() + got_fe), 1);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle_bits(1);

        // Stop bit low, line held low, then 0x81.
        send_frame(8'h5A, 1'b0, 1'b0);
        break_hold(40);
        check("break_ferr", 32'(got_fe), 1);
        send_frame(8'h81, 1'b1, 1'b0);
        idle_bits(1);

        // Back-to-back 0x00, 0xFF.
        n0 = got_cyc.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle_bits(1);
        check("b2b_spacing",
              32'((got_cyc.size() >= n0 + 2) ? got_cyc[n0+1] - got_cyc[n0] : -1), 160);

        // Reset during DATA of 0x77, then 0x12.
        n0 = got_q.size();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_bits(2);
        check("abort_none", 32'(got_q.size()), 32'(n0));
        send_frame(8'h12, 1'b1, 1'b0);
        idle_bits(1);
        check("after_rst_data", 32'(data_out), 32'h12);

`ifdef SERIAL_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1);
        idle_bits(1);
        check("par_err_pulse", 32'(got_pe), 1);
        send_frame(8'h03, 1'b1, 1'b0);
        idle_bits(1);
        check("par_ok_data", 32'(data_out), 32'h03);
`endif

        // Randomized mix of good frames, framing errors and glitches.
        for (int k = 0; k < 40; k++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                send_frame(DB'($urandom), 1'b0, 1'b0);
                break_hold($urandom_range(0, 60));
            end else if (kind == 1) begin
                glitch($urandom_range(1, 6));
            end else begin
`ifdef SERIAL_RX_PARITY_EN
                send_frame(DB'($urandom), 1'b1, ($urandom_range(0, 4) == 0));
`else
                send_frame(DB'($urandom), 1'b1, 1'b0);
`endif
                gap = $urandom_range(0, 2);
                if (gap > 0) idle_bits(gap);
            end
        end
        idle_bits(3);

        check("n_valid", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("data", 32'(got_q[i]), 32'(exp_q[i]));
        check("n_ferr", 32'(got_fe), 32'(exp_fe));
`ifdef SERIAL_RX_PARITY_EN
        check("n_perr", 32'(got_pe), 32'(exp_pe));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (even, >= 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame (5..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port data_out  output  DATA_BITS  last correctly framed byte, LSB received first.
REQ-007 SHALL have port valid  output  1  one-cycle pulse, data_out newly updated.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; all logic uses the synchronized value (rxs).
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
REQ-011 IDLE: on rxs=0 SHALL go to START with bit-cycle counter cleared.
REQ-012 START: at counter = CLKS_PER_BIT/2-1, rxs=0 -> DATA with counter cleared; rxs=1 -> IDLE (glitch rejected, no output pulse).
REQ-013 DATA: SHALL sample rxs every CLKS_PER_BIT cycles (mid-bit), shifting it into the MSB end of the shift register (LSB-first reception); after DATA_BITS samples -> STOP (or PARITY).
REQ-014 STOP: at mid-bit sample, rxs=1 -> load data_out from shift register, pulse valid for exactly one cycle, go to IDLE in the same cycle.
REQ-015 STOP: rxs=0 -> pulse frame_err for one cycle, leave data_out unchanged, go to BREAK.
REQ-016 BREAK: SHALL remain until rxs=1, then go to IDLE; no start detection while in BREAK.
REQ-017 valid and frame_err SHALL never be asserted in the same cycle.
REQ-018 Back-to-back frames: a start edge arriving half a bit after the stop-bit sample SHALL be received without loss.
REQ-019 data_out SHALL hold its value between valid pulses.
REQ-020 Counter width SHALL be $clog2(CLKS_PER_BIT); counter never exceeds CLKS_PER_BIT-1.

Reset
REQ-021 rst_n low SHALL immediately force state IDLE, counter 0, shift register 0, data_out 0, valid 0, frame_err 0, synchronizer flops 1.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; after release the block SHALL wait for a fresh falling edge on rxs.

Configuration
REQ-023 With macro SERIAL_RX_PARITY_EN defined: SHALL add PARITY state after DATA, sample one even-parity bit, and add output port parity_err  output  1  one-cycle pulse.
REQ-024 With macro defined: parity mismatch SHALL, at the STOP sample with rxs=1, pulse parity_err instead of valid and leave data_out unchanged; stop-bit low still yields frame_err only.
REQ-025 Without macro: no PARITY state, no parity_err port, frame = start + DATA_BITS + stop.

Verification (CLKS_PER_BIT=16, DATA_BITS=8)
REQ-026 Send 0xA5 (start,1,0,1,0,0,1,0,1,stop) -> single valid pulse, data_out=0xA5, valid ~ 9.5 bit times (152 cycles) plus 2 sync cycles after start edge.
REQ-027 Drive rx low 4 cycles then high -> no valid, no frame_err, FSM back in IDLE; following 0x3C frame received correctly.
REQ-028 Send 0x5A with stop bit 0, hold rx low 40 cycles, then send 0x81 -> one frame_err pulse, data_out stays previous value, then valid with 0x81.
REQ-029 Send 0x00 then 0xFF with no idle gap -> two valid pulses 160 cycles apart, data 0x00 then 0xFF.
REQ-030 Assert rst_n low during DATA of a 0x77 frame, release, send 0x12 -> all outputs 0 during reset, no pulse for aborted frame, valid with 0x12.
REQ-031 With SERIAL_RX_PARITY_EN: send 0x03 with parity bit 1 -> parity_err pulse, no valid; with parity bit 0 -> valid, data_out=0x03.
